// File: rtl/bus_arb_pkg.sv
// Shared types and limits for the round-robin memory-port arbiter.
package bus_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int MAX_REQ = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first asserted request scanning upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_priority_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   pick_idx
);

  int idx;

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        pick_idx = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one memory port among NUM_REQ valid/ready masters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                req_err,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              mem_valid,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic [DATA_WIDTH/8-1:0]           mem_wstrb,
  input  logic                              mem_ready,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  generate
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("bus_arbiter_rr: NUM_REQ must be in 2..4");
    end
  endgenerate

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             complete;
  logic             expire;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .pick_idx   (pick_idx)
  );

  assign complete = (state_q == BUSY) && mem_ready;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Counter is held at zero outside BUSY, so it always starts clean on entry.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == BUSY && !mem_ready) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
  end

  assign expire = (state_q == BUSY) && !mem_ready &&
                  (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    req_err      = '0;
    rsp_rdata    = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A dropped req_valid does not abort; only completion or timeout ends BUSY.
        if (complete || expire) begin
          req_ready[grant_q] = 1'b1;
          req_err[grant_q]   = expire;
          rsp_rdata          = complete ? mem_rdata : '0;
          last_grant_d       = grant_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign mem_valid = (state_q == BUSY);
  assign grant_id  = grant_q;
  assign mem_addr  = req_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_wdata = req_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign mem_wstrb = req_wstrb[int'(grant_q)*STRB_W +: STRB_W];

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with three requesters; watchdog cases are
// exercised when ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_bus_arbiter_rr;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_err;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [SW-1:0]   mem_wstrb;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    logic          rstn;
    logic [N-1:0]  req;
    logic          mr;
    logic [DW-1:0] rd;
    logic          exp_busy;
    logic [IW-1:0] exp_grant;
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] exp_rsp;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  bus_arbiter_rr #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .req_err   (req_err),
    .rsp_rdata (rsp_rdata),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic rstn, input logic [N-1:0] req,
                               input logic mr, input logic [DW-1:0] rd);
    @(negedge clk);
    resetn    = rstn;
    req_valid = req;
    mem_ready = mr;
    mem_rdata = rd;
    #1;
  endtask

  task automatic addVec(input logic rstn, input logic [N-1:0] req, input logic mr,
                        input logic [DW-1:0] rd, input logic eb, input logic [IW-1:0] eg,
                        input logic [N-1:0] er, input logic [DW-1:0] ersp,
                        input logic [AW-1:0] ea);
    vec_t v;
    v.rstn = rstn; v.req = req; v.mr = mr; v.rd = rd;
    v.exp_busy = eb; v.exp_grant = eg; v.exp_ready = er;
    v.exp_rsp = ersp; v.exp_addr = ea;
    vecs.push_back(v);
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    req_wdata = {32'h3333_3333, 32'hA5A5_1234, 32'h1111_1111};
    req_wstrb = {4'h0, 4'h3, 4'h0};

    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0);

    // Reset state, single requester with 3 stall cycles, IDLE mem_ready ignored.
    addVec(1, 3'b000, 0, 32'h0,          0, 0, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b001, 0, 32'h0,          0, 0, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b001, 0, 32'h0,          1, 0, 3'b000, 32'h0,          32'h100);
    addVec(1, 3'b001, 0, 32'h0,          1, 0, 3'b000, 32'h0,          32'h100);
    addVec(1, 3'b001, 0, 32'h0,          1, 0, 3'b000, 32'h0,          32'h100);
    addVec(1, 3'b001, 1, 32'hDEADBEEF,   1, 0, 3'b001, 32'hDEADBEEF,   32'h100);
    addVec(1, 3'b000, 1, 32'h1234_5678,  0, 0, 3'b000, 32'h0,          32'h0);
    // Fairness from reset: grants 0,1,2,0,1,2 with one IDLE cycle between.
    addVec(0, 3'b000, 0, 32'h0,          0, 0, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b111, 0, 32'h0,          0, 0, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b111, 1, 32'h11,         1, 0, 3'b001, 32'h11,         32'h100);
    addVec(1, 3'b111, 0, 32'h0,          0, 0, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b111, 1, 32'h22,         1, 1, 3'b010, 32'h22,         32'h200);
    addVec(1, 3'b111, 0, 32'h0,          0, 1, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b111, 1, 32'h33,         1, 2, 3'b100, 32'h33,         32'h300);
    addVec(1, 3'b111, 0, 32'h0,          0, 2, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b111, 1, 32'h44,         1, 0, 3'b001, 32'h44,         32'h100);
    addVec(1, 3'b111, 0, 32'h0,          0, 0, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b111, 1, 32'h55,         1, 1, 3'b010, 32'h55,         32'h200);
    addVec(1, 3'b111, 0, 32'h0,          0, 1, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b111, 1, 32'h66,         1, 2, 3'b100, 32'h66,         32'h300);
    addVec(1, 3'b000, 0, 32'h0,          0, 2, 3'b000, 32'h0,          32'h0);
    // Granted master drops req_valid mid-transaction; grant is held.
    addVec(1, 3'b010, 0, 32'h0,          0, 2, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b000, 0, 32'h0,          1, 1, 3'b000, 32'h0,          32'h200);
    addVec(1, 3'b000, 1, 32'h77,         1, 1, 3'b010, 32'h77,         32'h200);
    // Sparse requests skip idle masters and wrap.
    addVec(1, 3'b101, 0, 32'h0,          0, 1, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b101, 1, 32'h88,         1, 2, 3'b100, 32'h88,         32'h300);
    addVec(1, 3'b101, 0, 32'h0,          0, 2, 3'b000, 32'h0,          32'h0);
    addVec(1, 3'b101, 1, 32'h99,         1, 0, 3'b001, 32'h99,         32'h100);
    addVec(1, 3'b000, 0, 32'h0,          0, 0, 3'b000, 32'h0,          32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].req, vecs[i].mr, vecs[i].rd);
      checkOutput($sformatf("v%0d busy", i),      busy,      vecs[i].exp_busy);
      checkOutput($sformatf("v%0d mem_valid", i), mem_valid, vecs[i].exp_busy);
      checkOutput($sformatf("v%0d grant_id", i),  grant_id,  vecs[i].exp_grant);
      checkOutput($sformatf("v%0d req_ready", i), req_ready, vecs[i].exp_ready);
      checkOutput($sformatf("v%0d req_err", i),   req_err,   3'b000);
      checkOutput($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rsp);
      if (vecs[i].exp_busy) begin
        checkOutput($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      end
    end

    // Write path: requester 1 wins over requester 0 (last grant was 0).
    applyStimulus(1'b1, 3'b011, 1'b0, 32'h0);
    checkOutput("wr idle busy", busy, 1'b0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 3'b011, 1'b0, 32'h0);
      checkOutput("wr grant", grant_id, 2'd1);
      checkOutput("wr mem_wstrb", mem_wstrb, 4'h3);
      checkOutput("wr mem_wdata", mem_wdata, 32'hA5A5_1234);
      checkOutput("wr req_ready", req_ready, 3'b000);
    end
    applyStimulus(1'b1, 3'b011, 1'b1, 32'hCAFE_F00D);
    checkOutput("wr done req_ready", req_ready, 3'b010);
    checkOutput("wr done rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0);
    checkOutput("wr after busy", busy, 1'b0);

    // Reset on the second BUSY cycle of a grant to requester 2.
    applyStimulus(1'b1, 3'b100, 1'b0, 32'h0);
    checkOutput("rst idle busy", busy, 1'b0);
    applyStimulus(1'b1, 3'b100, 1'b0, 32'h0);
    checkOutput("rst busy1 busy", busy, 1'b1);
    checkOutput("rst busy1 grant", grant_id, 2'd2);
    applyStimulus(1'b0, 3'b100, 1'b0, 32'h0);
    checkOutput("rst busy2 req_ready", req_ready, 3'b000);
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0);
    checkOutput("rst after mem_valid", mem_valid, 1'b0);
    checkOutput("rst after busy", busy, 1'b0);
    checkOutput("rst after grant", grant_id, 2'd0);
    checkOutput("rst after req_ready", req_ready, 3'b000);

`ifdef ARB_TIMEOUT_EN
    // Watchdog fires on the 8th BUSY cycle without mem_ready.
    applyStimulus(1'b1, 3'b001, 1'b0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b1, 3'b001, 1'b0, 32'h5555_AAAA);
      checkOutput($sformatf("to c%0d busy", c), busy, 1'b1);
      checkOutput($sformatf("to c%0d req_ready", c), req_ready, (c == 8) ? 3'b001 : 3'b000);
      checkOutput($sformatf("to c%0d req_err", c), req_err, (c == 8) ? 3'b001 : 3'b000);
      checkOutput($sformatf("to c%0d rsp_rdata", c), rsp_rdata, 32'h0);
    end
    applyStimulus(1'b1, 3'b001, 1'b0, 32'h0);
    checkOutput("to after busy", busy, 1'b0);
    // mem_ready on the timeout cycle wins: normal completion, no error.
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b1, 3'b001, (c == 8), 32'h600D_DA7A);
      checkOutput($sformatf("race c%0d req_ready", c), req_ready, (c == 8) ? 3'b001 : 3'b000);
      checkOutput($sformatf("race c%0d req_err", c), req_err, 3'b000);
      checkOutput($sformatf("race c%0d rsp_rdata", c), rsp_rdata, (c == 8) ? 32'h600D_DA7A : 32'h0);
    end
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0);
    checkOutput("race after busy", busy, 1'b0);
`else
    // Without the watchdog, BUSY waits well past 8 cycles.
    applyStimulus(1'b1, 3'b001, 1'b0, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b1, 3'b001, 1'b0, 32'h5555_AAAA);
      checkOutput($sformatf("wait c%0d busy", c), busy, 1'b1);
      checkOutput($sformatf("wait c%0d req_ready", c), req_ready, 3'b000);
      checkOutput($sformatf("wait c%0d req_err", c), req_err, 3'b000);
    end
    applyStimulus(1'b1, 3'b001, 1'b1, 32'h600D_DA7A);
    checkOutput("wait done req_ready", req_ready, 3'b001);
    checkOutput("wait done rsp_rdata", rsp_rdata, 32'h600D_DA7A);
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0);
    checkOutput("wait after busy", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
